neo_irq_ctrl: RTL and testbench

// Interrupt controller feeding cpu_68k IPL1/IPL0 and snooping its bus for IRQ acknowledges.

---
 rtl/neo_irq_ctrl_if.sv | 23 ++
 rtl/neo_irq_ctrl.sv | 77 +++++++
 tb/tb_neo_irq_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/neo_irq_ctrl_if.sv
// CPU-side bus bundle seen by the interrupt controller: the 68k strobes,
// address and low data bits it snoops, and the IPL lines it drives back.
interface neo_irq_ctrl_if;
  logic        nAS;
  logic        M68K_RW;
  logic        nLDS;
  logic [23:1] M68K_ADDR;
  logic [2:0]  M68K_DATA;
  logic        IPL1;
  logic        IPL0;

  // CPU side: drives the bus, receives the interrupt level
  modport master (
    output nAS, M68K_RW, nLDS, M68K_ADDR, M68K_DATA,
    input  IPL1, IPL0
  );

  // Controller side: snoops the bus, drives the interrupt level
  modport slave (
    input  nAS, M68K_RW, nLDS, M68K_ADDR, M68K_DATA,
    output IPL1, IPL0
  );
endinterface : neo_irq_ctrl_if

// File: rtl/neo_irq_ctrl.sv
// Interrupt controller for the 68k: latches VBlank (lvl1), timer (lvl2) and
// cold-boot (lvl3) requests, presents the highest pending level active-low on
// IPL1/IPL0 and clears levels when software writes the low byte of REG_IRQACK.
module neo_irq_ctrl #(
  parameter logic [23:1] ACK_ADDR = 23'h1E0006,
  parameter bit          COLD_IRQ = 1'b1
) (
  input  logic          CLK_68KCLK,
  input  logic          RESET,
  input  logic          VBL_PULSE,
  input  logic          TMR_PULSE,
  input  logic          VBL_EN,
  input  logic          TMR_EN,
  neo_irq_ctrl_if.slave cpu_bus,
  output logic [2:0]    PENDING
);

  logic [2:0] pend_q, pend_d;
  logic [1:0] ipl_q, ipl_d;
  logic       armed_q, armed_d;
  logic       boot_q;
  logic       ack_hit;
  logic [2:0] set_vec;
  logic [2:0] clr_vec;

  // Decode an acknowledge write; armed_q makes it one-shot per bus cycle so
  // wait-stated writes clear only on the first edge of the cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    ack_hit = 1'b0;
    clr_vec = 3'b000;
    armed_d = armed_q;
    if (!cpu_bus.nAS && !cpu_bus.M68K_RW && !cpu_bus.nLDS &&
        (cpu_bus.M68K_ADDR == ACK_ADDR) && armed_q) begin
      ack_hit = 1'b1;
      // DATA[2] acks lvl1, DATA[1] lvl2, DATA[0] lvl3
      clr_vec = {cpu_bus.M68K_DATA[0], cpu_bus.M68K_DATA[1], cpu_bus.M68K_DATA[2]};
    end
    if (cpu_bus.nAS)  armed_d = 1'b1;
    else if (ack_hit) armed_d = 1'b0;
  end

  // Combine new requests with acknowledges; a set on the same edge beats the clear
  always_comb begin
    set_vec = {boot_q & COLD_IRQ, TMR_PULSE & TMR_EN, VBL_PULSE & VBL_EN};
    pend_d  = (pend_q & ~clr_vec) | set_vec;
  end

  // Priority-encode the currently registered pending flags into active-low IPL
  always_comb begin
    ipl_d = 2'b11;
    if      (pend_q[2]) ipl_d = 2'b00;
    else if (pend_q[1]) ipl_d = 2'b01;
    else if (pend_q[0]) ipl_d = 2'b10;
  end

  // State registers; boot_q marks the first edge after reset for the cold-boot request
  always_ff @(posedge CLK_68KCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RESET) begin
      pend_q  <= 3'b000;
      ipl_q   <= 2'b11;
      armed_q <= 1'b1;
      boot_q  <= 1'b1;
    end else begin
      pend_q  <= pend_d;
      ipl_q   <= ipl_d;
      armed_q <= armed_d;
      boot_q  <= 1'b0;
    end
  end

  assign PENDING      = pend_q;
  assign cpu_bus.IPL1 = ipl_q[1];
  assign cpu_bus.IPL0 = ipl_q[0];

endmodule : neo_irq_ctrl

// File: tb/tb_neo_irq_ctrl.sv
// Self-checking bench for neo_irq_ctrl: a level-oriented model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_neo_irq_ctrl;

  localparam logic [23:1] ACK = 23'h1E0006;

  logic clk = 1'b0;
  logic rst;
  logic vbl, tmr, vbl_en, tmr_en;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  neo_irq_ctrl_if bus ();

  neo_irq_ctrl #(.ACK_ADDR(ACK), .COLD_IRQ(1'b1)) dut (
    .CLK_68KCLK (clk),
    .RESET      (rst),
    .VBL_PULSE  (vbl),
    .TMR_PULSE  (tmr),
    .VBL_EN     (vbl_en),
    .TMR_EN     (tmr_en),
    .cpu_bus    (bus),
    .PENDING    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Levels 1..3 are kept as booleans; IPL is simply 3 minus the highest
  // pending level of the previous cycle.
  bit m_lvl [1:3];
  bit m_boot;
  bit m_acked;
  int m_ipl;
  bit m_valid = 1'b0;

  function automatic int highest(input bit l1, input bit l2, input bit l3);
    int h = 0;
    if (l1) h = 1;
    if (l2) h = 2;
    if (l3) h = 3;
    return h;
  endfunction

  always @(posedge clk) begin
    bit hit;
    bit req [1:3];
    bit clr [1:3];
    if (rst) begin
      for (int l = 1; l <= 3; l++) m_lvl[l] = 1'b0;
      m_boot  = 1'b1;
      m_acked = 1'b0;
      m_ipl   = 3;
    end else begin
      m_ipl = 3 - highest(m_lvl[1], m_lvl[2], m_lvl[3]);
      hit = (bus.nAS == 1'b0) && (bus.M68K_RW == 1'b0) && (bus.nLDS == 1'b0) &&
            (bus.M68K_ADDR == ACK) && !m_acked;
      req[1] = vbl && vbl_en;
      req[2] = tmr && tmr_en;
      req[3] = m_boot;
      for (int l = 1; l <= 3; l++) begin
        clr[l]   = hit && bus.M68K_DATA[3-l];
        m_lvl[l] = req[l] || (m_lvl[l] && !clr[l]);
      end
      m_acked = bus.nAS ? 1'b0 : (m_acked || hit);
      m_boot  = 1'b0;
    end
    m_valid = 1'b1;
  end

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pending", int'(pending), int'({m_lvl[3], m_lvl[2], m_lvl[1]}));
      check("model_ipl", int'({bus.IPL1, bus.IPL0}), m_ipl);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.nAS       = 1'b1;
    bus.M68K_RW   = 1'b1;
    bus.nLDS      = 1'b1;
    bus.M68K_ADDR = '0;
    bus.M68K_DATA = '0;
  endtask

  task automatic bus_drive(input logic [23:1] addr, input logic [2:0] data,
                           input logic rw, input logic nlds);
    bus.nAS       = 1'b0;
    bus.M68K_RW   = rw;
    bus.nLDS      = nlds;
    bus.M68K_ADDR = addr;
    bus.M68K_DATA = data;
  endtask

  // Full bus cycle held 1+waits edges, then one idle edge so IPL has settled
  task automatic bus_cycle(input logic [23:1] addr, input logic [2:0] data,
                           input logic rw, input logic nlds, input int waits);
    bus_drive(addr, data, rw, nlds);
    tick(1 + waits);
    bus_idle();
    tick();
  endtask

  task automatic ack(input logic [2:0] data);
    bus_cycle(ACK, data, 1'b0, 1'b0, 0);
  endtask

  task automatic pulse_vbl();
    vbl = 1'b1; tick(); vbl = 1'b0;
  endtask

  task automatic pulse_tmr();
    tmr = 1'b1; tick(); tmr = 1'b0;
  endtask

  function automatic int ipl_now();
    return int'({bus.IPL1, bus.IPL0});
  endfunction

  // ---------------- directed sequences ----------------
  initial begin
    rst = 1'b1; vbl = 1'b0; tmr = 1'b0; vbl_en = 1'b1; tmr_en = 1'b1;
    bus_idle();
    tick(3);
    check("reset_pending", int'(pending), 0);
    check("reset_ipl", ipl_now(), 3);

    // Cold boot: P[2] on first edge, IPL one edge later
    rst = 1'b0;
    tick();
    check("cold_pending", int'(pending), 3'b100);
    check("cold_ipl_lag", ipl_now(), 3);
    tick();
    check("cold_ipl", ipl_now(), 0);
    ack(3'b001);
    check("cold_ack_pending", int'(pending), 0);
    check("cold_ack_ipl", ipl_now(), 3);

    // VBlank then timer, acked in turn
    pulse_vbl();
    check("vbl_pending", int'(pending), 3'b001);
    tick();
    check("vbl_ipl", ipl_now(), 2);
    pulse_tmr();
    check("tmr_pending", int'(pending), 3'b011);
    tick();
    check("tmr_ipl", ipl_now(), 1);
    ack(3'b010);
    check("ack_tmr_pending", int'(pending), 3'b001);
    check("ack_tmr_ipl", ipl_now(), 2);
    ack(3'b100);
    check("ack_vbl_pending", int'(pending), 0);
    check("ack_vbl_ipl", ipl_now(), 3);

    // Disabled timer pulse is dropped, not deferred
    tmr_en = 1'b0;
    pulse_tmr();
    tick();
    check("tmr_dis_pending", int'(pending), 0);
    check("tmr_dis_ipl", ipl_now(), 3);
    tmr_en = 1'b1;
    tick(2);
    check("tmr_en_late", int'(pending), 0);

    // Wait-stated ack of lvl1 with a VBlank on cycle 3: ack already spent
    bus_drive(ACK, 3'b100, 1'b0, 1'b0);
    tick(2);
    vbl = 1'b1; tick(); vbl = 1'b0;
    tick(2);
    bus_idle();
    tick();
    check("wait_ack_oneshot", int'(pending), 3'b001);
    ack(3'b100);
    check("wait_cleanup", int'(pending), 0);

    // Set and ack of lvl1 on the same edge: set wins
    bus_drive(ACK, 3'b100, 1'b0, 1'b0);
    vbl = 1'b1; tick(); vbl = 1'b0;
    check("set_beats_ack", int'(pending), 3'b001);
    bus_idle();
    tick();

    // Upper-byte write, wrong address, read: all ignored
    bus_cycle(ACK, 3'b111, 1'b0, 1'b1, 0);
    check("upper_byte", int'(pending), 3'b001);
    bus_cycle(23'h1E0007, 3'b111, 1'b0, 1'b0, 0);
    check("wrong_addr", int'(pending), 3'b001);
    bus_cycle(ACK, 3'b111, 1'b1, 1'b0, 0);
    check("read_ack", int'(pending), 3'b001);
    check("ignored_ipl", ipl_now(), 2);

    // Re-pulse while pending has no extra effect; one ack clears it
    pulse_vbl();
    ack(3'b100);
    check("repulse_ack", int'(pending), 0);

    // Reset while lvl2 pending, with an ack write still on the bus
    pulse_tmr();
    check("pre_reset_lvl2", int'(pending), 3'b010);
    bus_drive(ACK, 3'b001, 1'b0, 1'b0);
    rst = 1'b1;
    tick(2);
    check("reset_mid_pending", int'(pending), 0);
    check("reset_mid_ipl", ipl_now(), 3);
    rst = 1'b0;
    tick();
    // cold set and the post-reset ack hit coincide: set wins
    check("reset_cold_vs_ack", int'(pending), 3'b100);
    tick(2);
    bus_idle();
    tick();
    check("reset_ack_once", int'(pending), 3'b100);
    check("reset_ack_ipl", ipl_now(), 0);
    ack(3'b001);
    check("final_pending", int'(pending), 0);
    check("final_ipl", ipl_now(), 3);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_neo_irq_ctrl
